debug_run_controller: RTL

- Command sequencer between the UART receiver and the MIPS pipeline.
- Decodes host command bytes to:
  - load instruction memory;
  - reset the pipeline;
  - single-step or free-run the pipeline.
- After every step or run it requests a state dump from the debug dump unit and waits for that dump to finish.
- Sole owner of the pipeline enable, the pipeline reset and the instruction-memory write port.

---
 rtl/debug_run_controller.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/debug_run_controller.sv
// debug_run_controller
//   Command sequencer between the UART receiver and the MIPS pipeline.
//   Host bytes: 'l' load instruction memory, 'r' reset pipeline,
//   's' single step, 'c' free run. Every step or run ends with a dump
//   request; the controller then waits for the dump unit to finish.
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_uart_rx_ready/_data     received byte strobe and value
//   i_mips_halt               HALT reached writeback
//   i_dump_done               dump unit finished
//   o_imem_wr_en/_addr/_data  instruction memory write port
//   o_mips_enable             pipeline clock enable
//   o_mips_reset              synchronous pipeline reset pulse
//   o_dump_req                one-cycle dump request
//   o_load_error              one-cycle pulse: word count rejected
//   o_halted                  sticky halted flag
//   o_state                   current state, for debug
module debug_run_controller #(
    parameter int NB             = 32,
    parameter int DATA_BITS      = 8,
    parameter int IMEM_WORDS     = 64,
    parameter int MAX_RUN_CYCLES = 1024,
    parameter int NB_STATE       = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_uart_rx_ready,
    input  logic [DATA_BITS-1:0] i_uart_rx_data,
    input  logic                 i_mips_halt,
    input  logic                 i_dump_done,
    output logic                 o_imem_wr_en,
    output logic [NB-1:0]        o_imem_wr_addr,
    output logic [NB-1:0]        o_imem_wr_data,
    output logic                 o_mips_enable,
    output logic                 o_mips_reset,
    output logic                 o_dump_req,
    output logic                 o_load_error,
    output logic                 o_halted,
    output logic [NB_STATE-1:0]  o_state
);

    localparam int BYTES_PER_WORD = NB / DATA_BITS;
    localparam int BC_W = $clog2(BYTES_PER_WORD);
    localparam int WL_W = $clog2(IMEM_WORDS + 1);
    localparam int RC_W = $clog2(MAX_RUN_CYCLES);

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] LOAD_COUNT = 4'd1;
    localparam logic [3:0] LOAD_BYTE  = 4'd2;
    localparam logic [3:0] LOAD_WRITE = 4'd3;
    localparam logic [3:0] PIPE_RESET = 4'd4;
    localparam logic [3:0] STEP       = 4'd5;
    localparam logic [3:0] RUN        = 4'd6;
    localparam logic [3:0] DUMP_REQ   = 4'd7;
    localparam logic [3:0] DUMP_WAIT  = 4'd8;

    localparam logic [DATA_BITS-1:0] CMD_LOAD  = DATA_BITS'(8'h6C);
    localparam logic [DATA_BITS-1:0] CMD_RESET = DATA_BITS'(8'h72);
    localparam logic [DATA_BITS-1:0] CMD_STEP  = DATA_BITS'(8'h73);
    localparam logic [DATA_BITS-1:0] CMD_CONT  = DATA_BITS'(8'h63);

    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES_PER_WORD - 1);
    localparam logic [RC_W-1:0] RUN_LAST  = RC_W'(MAX_RUN_CYCLES - 1);

    logic [3:0]      state;
    logic [3:0]      state_next;
    logic [NB-1:0]   word;
    logic [BC_W-1:0] byte_cnt;
    logic [WL_W-1:0] words_left;
    logic [NB-1:0]   wr_addr;
    logic [RC_W-1:0] run_cnt;
    logic            halted;
    logic            load_error;

    logic [31:0]     count_val;
    logic            count_ok;
    logic            run_exit;

    assign count_val = 32'(i_uart_rx_data);
    assign count_ok  = (count_val != '0) && (count_val <= 32'(IMEM_WORDS));
    // Halt and watchdog limit share one exit, so a coincident pair is a single transition.
    assign run_exit  = i_mips_halt || (run_cnt == RUN_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_uart_rx_ready) begin
                    if (i_uart_rx_data == CMD_LOAD)
                        state_next = LOAD_COUNT;
                    else if (i_uart_rx_data == CMD_RESET)
                        state_next = PIPE_RESET;
                    else if (i_uart_rx_data == CMD_STEP)
                        state_next = halted ? DUMP_REQ : STEP;
                    else if (i_uart_rx_data == CMD_CONT)
                        state_next = halted ? DUMP_REQ : RUN;
                end
            end
            LOAD_COUNT: if (i_uart_rx_ready) state_next = count_ok ? LOAD_BYTE : IDLE;
            LOAD_BYTE:  if (i_uart_rx_ready && byte_cnt == LAST_BYTE) state_next = LOAD_WRITE;
            LOAD_WRITE: state_next = (words_left == WL_W'(1)) ? PIPE_RESET : LOAD_BYTE;
            PIPE_RESET: state_next = IDLE;
            STEP:       state_next = DUMP_REQ;
            RUN:        if (run_exit) state_next = DUMP_REQ;
            DUMP_REQ:   state_next = DUMP_WAIT;
            DUMP_WAIT:  if (i_dump_done) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            word       <= '0;
            byte_cnt   <= '0;
            words_left <= '0;
            wr_addr    <= '0;
            run_cnt    <= '0;
            halted     <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state      <= state_next;
            load_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_uart_rx_ready && i_uart_rx_data == CMD_CONT)
                        run_cnt <= '0;
                end
                LOAD_COUNT: begin
                    if (i_uart_rx_ready) begin
                        if (count_ok) begin
                            words_left <= WL_W'(count_val);
                            wr_addr    <= '0;
                            byte_cnt   <= '0;
                        end else begin
                            load_error <= 1'b1;
                        end
                    end
                end
                LOAD_BYTE: begin
                    if (i_uart_rx_ready) begin
                        // Big-endian assembly: the first byte ends in the top lane.
                        word     <= {word[NB-DATA_BITS-1:0], i_uart_rx_data};
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                LOAD_WRITE: begin
                    wr_addr    <= wr_addr + NB'(4);
                    words_left <= words_left - 1'b1;
                end
                PIPE_RESET: halted <= 1'b0;
                STEP: begin
                    if (i_mips_halt) halted <= 1'b1;
                end
                RUN: begin
                    if (i_mips_halt) halted <= 1'b1;
                    // Counter freezes on exit so it never wraps past the limit.
                    if (!run_exit) run_cnt <= run_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_imem_wr_en   = (state == LOAD_WRITE);
    assign o_imem_wr_addr = wr_addr;
    assign o_imem_wr_data = word;
    assign o_mips_enable  = (state == RUN) || (state == STEP);
    assign o_mips_reset   = (state == PIPE_RESET);
    assign o_dump_req     = (state == DUMP_REQ);
    assign o_load_error   = load_error;
    assign o_halted       = halted;
    assign o_state        = NB_STATE'(state);

endmodule
